// File: rtl/soc_system_v5_aux_cnt_in.sv
// Avalon-MM edge-capture input port: synchronized DATA, IRQMASK, sticky EDGECAP, level irq.
// Build option: define AUX_CNT_IN_BITCLR_EN so EDGECAP writes clear only the bits written as 1.
module soc_system_v5_aux_cnt_in #(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int GUARD_MAX = SYNC_STAGES + 1;
  localparam int GW        = $clog2(GUARD_MAX + 1);
  localparam logic [GW-1:0] GUARD_DONE = GW'(GUARD_MAX);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_mask;
  logic [WIDTH-1:0]                  r_cap;
  logic [GW-1:0]                     r_guard;
  logic [31:0]                       r_readdata;

  logic [WIDTH-1:0] w_d_sync;
  logic [WIDTH-1:0] w_edge_raw;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_cap_next;
  logic [31:0]      w_rd_next;
  logic             w_wr;
  logic             w_edge_en;

  assign w_d_sync  = r_sync[SYNC_STAGES-1];
  assign w_wr      = chipselect & ~write_n;
  assign w_edge_en = (r_guard == GUARD_DONE);

  // Synchronizer chain plus the one-cycle-older copy used for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
      r_prev <= w_d_sync;
    end
  end

  // Holds off capture until the chain has flushed the levels seen at reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_guard <= '0;
    end else if (r_guard != GUARD_DONE) begin
      r_guard <= r_guard + 1'b1;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_edge_raw = w_d_sync & ~r_prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_edge_raw = ~w_d_sync & r_prev;
    end else begin : g_any
      assign w_edge_raw = w_d_sync ^ r_prev;
    end
  endgenerate

  assign w_edge = w_edge_en ? w_edge_raw : '0;

`ifdef AUX_CNT_IN_BITCLR_EN
  assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
`else
  assign w_clr = {WIDTH{w_wr && (address == ADDR_EDGECAP)}};
`endif

  // A new edge wins over a simultaneous clear so no event is lost
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_cap_next[gi] = (r_cap[gi] & ~w_clr[gi]) | w_edge[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap  <= '0;
      r_mask <= '0;
    end else begin
      r_cap <= w_cap_next;
      if (w_wr && (address == ADDR_IRQMASK)) begin
        r_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rd_next = '0;
    case (address)
      ADDR_DATA:    w_rd_next[WIDTH-1:0] = w_d_sync;
      ADDR_IRQMASK: w_rd_next[WIDTH-1:0] = r_mask;
      ADDR_EDGECAP: w_rd_next[WIDTH-1:0] = r_cap;
      default:      w_rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_next;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_soc_system_v5_aux_cnt_in.sv
// Bench for soc_system_v5_aux_cnt_in: directed vector table, corner sequences and random traffic
// checked against a delay-line reference model; two instances cover different parameter sets.
module tb_soc_system_v5_aux_cnt_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  always #5 clk = ~clk;

  soc_system_v5_aux_cnt_in u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  soc_system_v5_aux_cnt_in #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(3)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]),
    .readdata(rd1), .irq(irq1)
  );

`ifdef AUX_CNT_IN_BITCLR_EN
  localparam bit BITCLR = 1'b1;
`else
  localparam bit BITCLR = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  a;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] din;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;
  vec_t vt[$];

  // Reference model: each instance sees in_port delayed by its stage count;
  // registers follow the register-map rules directly.
  int          p_w [2];
  int          p_et[2];
  int          p_s [2];
  logic [31:0] m_hist[2][5];
  int          m_cnt [2];
  logic [31:0] m_mask[2];
  logic [31:0] m_cap [2];
  logic [31:0] m_rd  [2];

  function automatic logic [31:0] wmask(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << w) - 32'h1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 5; k++) m_hist[i][k] = '0;
      m_cnt[i]  = 0;
      m_mask[i] = '0;
      m_cap[i]  = '0;
      m_rd[i]   = '0;
    end
  endtask

  task automatic model_step();
    logic [31:0] m, ds, dp, edg, clr, rdn;
    logic        wr;
    for (int i = 0; i < 2; i++) begin
      m  = wmask(p_w[i]);
      ds = m_hist[i][p_s[i]-1];
      dp = m_hist[i][p_s[i]];
      case (p_et[i])
        0:       edg = ds & ~dp;
        1:       edg = ~ds & dp;
        default: edg = ds ^ dp;
      endcase
      if (m_cnt[i] < p_s[i] + 1) edg = '0;
      wr = chipselect && !write_n;
      case (address)
        2'd0:    rdn = ds & m;
        2'd2:    rdn = m_mask[i];
        2'd3:    rdn = m_cap[i];
        default: rdn = '0;
      endcase
      if (wr && address == 2'd3) clr = BITCLR ? writedata : 32'hFFFF_FFFF;
      else clr = '0;
      if (wr && address == 2'd2) m_mask[i] = writedata & m;
      m_cap[i] = ((m_cap[i] & ~clr) | edg) & m;
      m_rd[i]  = rdn;
      for (int k = 4; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = in_port & m;
      if (m_cnt[i] < 15) m_cnt[i]++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_rd0"},  rd0,         m_rd[0]);
    chk({tag, "_irq0"}, {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
    chk({tag, "_rd1"},  rd1,         m_rd[1]);
    chk({tag, "_irq1"}, {31'd0, irq1}, {31'd0, |(m_cap[1] & m_mask[1])});
  endtask

  // One bus cycle: drive at the falling edge, clock, return at the next falling edge
  task automatic cyc(input logic [1:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd, input logic [31:0] din);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_port    = din;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd_cyc(input logic [1:0] a, input logic [31:0] din);
    cyc(a, 1'b1, 1'b1, 32'h0, din);
  endtask

  task automatic wr_cyc(input logic [1:0] a, input logic [31:0] wd, input logic [31:0] din);
    cyc(a, 1'b1, 1'b0, wd, din);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic add(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd,
                     input logic [31:0] din, input logic [31:0] erd, input logic eirq);
    vec_t v;
    v.a = a; v.cs = cs; v.wn = wn; v.wd = wd; v.din = din; v.exp_rd = erd; v.exp_irq = eirq;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_clr;
    logic [31:0] din;
    p_w[0] = 32; p_et[0] = 0; p_s[0] = 2;
    p_w[1] = 8;  p_et[1] = 2; p_s[1] = 3;
    exp_clr = BITCLR ? 32'h1 : 32'h0;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 32'h0000_00FF;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_rd0", rd0, 32'h0);
    chk("reset_irq0", {31'd0, irq0}, 32'h0);
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_irq1", {31'd0, irq1}, 32'h0);
    reset_n = 1'b1;

    // Levels at release, DATA visible, no capture; then rise/fall on bit0 and clears
    add(2'd0, 1, 1, 0, 32'hFF, 32'h00, 0);
    add(2'd0, 1, 1, 0, 32'hFF, 32'h00, 0);
    for (int i = 0; i < 6; i++) add(2'd0, 1, 1, 0, 32'hFF, 32'hFF, 0);
    add(2'd3, 1, 1, 0, 32'hFF, 32'h0, 0);
    add(2'd2, 1, 0, 32'h1, 32'hFF, 32'h0, 0);
    for (int i = 0; i < 4; i++) add(2'd3, 1, 1, 0, 32'hFE, 32'h0, 0);
    add(2'd3, 1, 1, 0, 32'hFF, 32'h0, 0);
    add(2'd3, 1, 1, 0, 32'hFF, 32'h0, 0);
    add(2'd3, 1, 1, 0, 32'hFF, 32'h0, 1);
    add(2'd3, 1, 1, 0, 32'hFF, 32'h1, 1);
    add(2'd2, 1, 0, 32'h2, 32'hFD, 32'h1, 0);
    for (int i = 0; i < 3; i++) add(2'd3, 1, 1, 0, 32'hFD, 32'h1, 0);
    add(2'd3, 1, 1, 0, 32'hFF, 32'h1, 0);
    add(2'd3, 1, 1, 0, 32'hFF, 32'h1, 0);
    add(2'd3, 1, 1, 0, 32'hFF, 32'h1, 1);
    add(2'd3, 1, 1, 0, 32'hFF, 32'h3, 1);
    add(2'd3, 1, 0, 32'h2, 32'hFF, 32'h3, 0);
    add(2'd3, 1, 1, 0, 32'hFF, exp_clr, 0);
    add(2'd0, 1, 0, 32'hDEAD_BEEF, 32'hFF, 32'hFF, 0);
    add(2'd1, 1, 0, 32'hFFFF_FFFF, 32'hFF, 32'h0, 0);
    add(2'd2, 1, 1, 0, 32'hFF, 32'h2, 0);
    add(2'd1, 1, 1, 0, 32'hFF, 32'h0, 0);
    add(2'd3, 1, 1, 0, 32'hFF, exp_clr, 0);

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].a, vt[i].cs, vt[i].wn, vt[i].wd, vt[i].din);
      chk($sformatf("vec%0d_rd", i), rd0, vt[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq0}, {31'd0, vt[i].exp_irq});
      check_model($sformatf("vec%0d", i));
    end

    // Edge and clear land on the same EDGECAP bit in the same cycle
    rd_cyc(2'd0, 32'hFF);
    wr_cyc(2'd3, 32'hFFFF_FFFF, 32'hFF);
    repeat (3) rd_cyc(2'd0, 32'hFE);
    rd_cyc(2'd0, 32'hFF);
    rd_cyc(2'd0, 32'hFF);
    wr_cyc(2'd3, 32'hFFFF_FFFF, 32'hFF);
    rd_cyc(2'd3, 32'hFF);
    chk("collide_cap0", rd0, 32'h1);
    check_model("collide");

    // Any-edge instance: two toggles of bit5 with the mask closed, then open it
    repeat (6) rd_cyc(2'd0, 32'hFF);
    wr_cyc(2'd3, 32'hFFFF_FFFF, 32'hFF);
    wr_cyc(2'd2, 32'h0, 32'hFF);
    repeat (10) rd_cyc(2'd0, 32'hDF);
    repeat (10) rd_cyc(2'd0, 32'hFF);
    rd_cyc(2'd3, 32'hFF);
    chk("any_cap1", rd1, 32'h20);
    chk("any_irq1_masked", {31'd0, irq1}, 32'h0);
    chk("rise_cap0", rd0, 32'h20);
    wr_cyc(2'd2, 32'h20, 32'hFF);
    chk("any_irq1_open", {31'd0, irq1}, 32'h1);
    check_model("any");

    // Full EDGECAP with irq high, then reset dropped between clock edges
    repeat (5) rd_cyc(2'd0, 32'h0);
    repeat (5) rd_cyc(2'd0, 32'hFFFF_FFFF);
    wr_cyc(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd_cyc(2'd3, 32'hFFFF_FFFF);
    chk("full_cap0", rd0, 32'hFFFF_FFFF);
    chk("full_irq0", {31'd0, irq0}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rd0", rd0, 32'h0);
    chk("async_irq0", {31'd0, irq0}, 32'h0);
    chk("async_rd1", rd1, 32'h0);
    chk("async_irq1", {31'd0, irq1}, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) rd_cyc(2'd3, 32'hFFFF_FFFF);
    chk("post_rst_cap0", rd0, 32'h0);
    rd_cyc(2'd2, 32'hFFFF_FFFF);
    chk("post_rst_mask0", rd0, 32'h0);
    check_model("post_rst");

    // Random traffic against the model, including one mid-run reset
    din = 32'hFFFF_FFFF;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        do_reset();
      end
      if ($urandom_range(0, 3) == 0) din = din ^ ($urandom & $urandom);
      cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0), $urandom, din);
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_system_v5_aux_cnt_in.md
SOC_SYSTEM_V5_AUX_CNT_IN -- requirements
Module: soc_system_v5_aux_cnt_in

Interface
REQ-001 Parameter WIDTH, default 32: input port width, 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: edge type that sets capture bits (0 rising, 1 falling, 2 any).
REQ-003 Parameter SYNC_STAGES, default 2: number of synchronizer flops on in_port, 2..4.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external inputs.
REQ-011 readdata  output  32  registered read data; bits above WIDTH read 0.
REQ-012 irq  output  1  level interrupt to HPS.

Function
REQ-013 Register map SHALL be: addr 0 DATA (RO, synchronized in_port), addr 1 reserved (reads 0, writes ignored), addr 2 IRQMASK (RW, WIDTH bits), addr 3 EDGECAP (read; write clears).
REQ-014 in_port SHALL pass through SYNC_STAGES flops; the last stage is d_sync; one further flop holds d_prev.
REQ-015 Per bit, edge SHALL be d_sync&~d_prev (EDGE_TYPE 0), ~d_sync&d_prev (1), d_sync^d_prev (2).
REQ-016 An edge SHALL set its EDGECAP bit on the next clk edge; bits stay set until cleared by write or reset.
REQ-017 An in_port change set up before clk edge 1 SHALL appear in EDGECAP and irq after edge SYNC_STAGES+1.
REQ-018 readdata SHALL be registered every cycle from the current address (read latency 1), regardless of chipselect.
REQ-019 A write (chipselect & ~write_n) to addr 2 SHALL load IRQMASK from writedata[WIDTH-1:0] on that clk edge.
REQ-020 irq SHALL be the OR over bits of (EDGECAP & IRQMASK), driven combinationally from registers; no glitch from writedata.
REQ-021 If an edge and a clear hit the same EDGECAP bit in the same cycle, the bit SHALL end set.
REQ-022 Writes to addr 0 and addr 1 SHALL have no effect.
REQ-023 Edge detection SHALL be suppressed by a guard counter for SYNC_STAGES+1 cycles after reset deassertion, so input levels present at reset release do not capture.

Reset
REQ-024 On reset_n low: sync flops, d_prev, IRQMASK, EDGECAP, readdata, and guard counter SHALL be 0; irq SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL clear all state immediately; pending captures are lost.
REQ-026 Reset deassertion SHALL be consumed synchronously; the first capture is possible at clk edge SYNC_STAGES+2 after release.

Configuration
REQ-027 Macro AUX_CNT_IN_BITCLR_EN defined: a write to addr 3 SHALL clear only EDGECAP bits where writedata is 1.
REQ-028 Macro AUX_CNT_IN_BITCLR_EN undefined: any write to addr 3 SHALL clear all EDGECAP bits regardless of writedata.

Verification
REQ-029 Reset, release, hold in_port=0x0000_00FF -> after 8 cycles readdata(addr 0)=0x0000_00FF, EDGECAP=0, irq=0.
REQ-030 EDGE_TYPE=0, IRQMASK=0x1, in_port bit0 0->1 -> EDGECAP=0x1 and irq=1 exactly SYNC_STAGES+1 edges later; 1->0 causes no change.
REQ-031 EDGECAP=0x3, IRQMASK=0x2, write 0x2 to addr 3 -> BITCLR_EN: EDGECAP=0x1, irq=0; without the macro: EDGECAP=0, irq=0.
REQ-032 Clear write to addr 3 in the same cycle bit0 edge is detected -> EDGECAP bit0=1 afterwards.
REQ-033 EDGE_TYPE=2, toggle bit5 twice 10 cycles apart, IRQMASK=0 -> EDGECAP=0x20, irq=0; then write IRQMASK=0x20 -> irq=1 the next cycle.
REQ-034 Assert reset_n low with EDGECAP=0xFFFF_FFFF, irq=1 -> EDGECAP=0, IRQMASK=0, irq=0 without waiting for clk.
